alu_scheduler: RTL and testbench
================================

# alu_scheduler

Sequential front-end that shares one 8-bit add/subtract/bitwise/compare datapath between two requesters. Each requester offers an operation with valid/ready. The scheduler arbitrates, latches the operands and executes one operation. It then holds a tagged, registered result on a valid/ready output port until the port accepts it. It sits between the two command sources and the arithmetic unit and replaces free-running `sel`-driven selection with handshaked, one-at-a-time execution.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; the test plan uses 8.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester N offers an operation.
- `req0_ready` / `req1_ready`  out  1  requester N's operation is accepted this cycle.
- `req0_sel` / `req1_sel`  in  2  opcode: 00 add, 01 sub, 10 AND, 11 compare.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_id`  out  1  index of the requester that owns the result.
- `out_result`  out  WIDTH  result value.
- `out_cout`  out  1  carry / no-borrow flag.
- `out_gt`, `out_eq`, `out_lt`  out  1  compare flags.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM with three states: IDLE, EXEC, HOLD.
- IDLE: if any `reqN_valid` is high, grant one requester and assert its `reqN_ready` combinationally in that cycle. Latch id, sel, a and b, then go to EXEC. With no request, stay in IDLE.
- EXEC: compute from the latched operands, register all result fields, then go to HOLD.
- HOLD: `out_valid`=1. When `out_ready`=1, the transfer completes and the FSM returns to IDLE. There is no new grant in that same cycle.
- `reqN_ready` is never asserted outside IDLE. Requests stay pending untouched.
- Arithmetic:
  - add: result = (a+b) mod 2^WIDTH; cout = carry out.
  - sub: result = (a−b) mod 2^WIDTH; cout = carry of a+~b+1, so 1 means no borrow.
  - AND: result = a&b; cout = 0.
  - compare: result = 0; cout = 0; exactly one of gt/eq/lt is high, comparing a and b as unsigned.
- For non-compare ops, gt, eq and lt are all 0.
- Operand changes after acceptance have no effect on the result.

## Timing
- Request accepted in cycle T: EXEC in T+1, `out_valid` rises at T+2.
- If `out_ready` is held high, the next grant is in T+3. Peak throughput is one op per 3 cycles.
- Outputs are registered and stable while `out_valid`=1 and `out_ready`=0.
- Reset (asynchronous, any state, including mid-EXEC or mid-HOLD):
  - FSM returns to IDLE.
  - `out_valid`, `out_id`, `out_result`, `out_cout`, `out_gt`, `out_eq`, `out_lt` and `busy` all go to 0.
  - The in-flight operation is discarded.
  - Last-grant register = 1, so requester 0 wins the first tie.
- `reqN_ready` is 0 during reset.

## Configuration
- `ALU_SCHED_RR_EN` defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. The last-grant register updates on every grant.
- Undefined: fixed priority. Requester 0 always wins a tie, and the last-grant register is not built.
- Single-requester behaviour is identical in both builds.

## Structure
- Package `alu_sched_pkg`:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_CMP`;
  - state enum IDLE/EXEC/HOLD;
  - default `WIDTH`.
- Sub-module `alu_core`: purely combinational datapath. Inputs: a, b, sel. Outputs: result, cout, gt, eq, lt. It is instantiated once, fed from the latched operands.

## Test plan
- Req0 only: add, a=8'hF0, b=8'h20 → `out_valid` at T+2; result=8'h10, cout=1, id=0.
- Req1 only: sub, a=8'h05, b=8'h07 → result=8'hFE, cout=0. Then compare a=8'h33, b=8'h33 → result=0, eq=1, gt=0, lt=0.
- Both requesters valid for 4 consecutive ops, `out_ready`=1:
  - `ALU_SCHED_RR_EN` defined → ids 0,1,0,1.
  - Undefined → ids 0,0,0,0.
- Backpressure: `out_ready`=0 for 5 cycles after an AND of a=8'hCC, b=8'h0F → result holds at 8'h0C; both `reqN_ready`=0 throughout; grant occurs only after acceptance.
- Reset asserted in EXEC → `out_valid`=0 and `busy`=0 immediately. After release, a pending tie grants requester 0 first.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler.
// Opcodes, FSM states and the default datapath width.
package alu_sched_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/and/compare datapath.
// Sub carry is from a + ~b + 1, so cout=1 means no borrow.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b}
             + {{WIDTH{1'b0}}, 1'b1};

  // Opcode decode; flags default low
  always_comb begin
    result = '0;
    cout   = 1'b0;
    gt     = 1'b0;
    eq     = 1'b0;
    lt     = 1'b0;
    unique case (sel)
      OP_ADD: {cout, result} = sum;
      OP_SUB: {cout, result} = dif;
      OP_AND: result = a & b;
      OP_CMP: begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Handshaked one-at-a-time scheduler sharing alu_core between two requesters.
// ALU_SCHED_RR_EN selects round-robin ties; default is fixed priority to req0.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_lt,
  output logic             busy
);

  state_t state, state_nx;

  logic             pick1;
  logic             grant;
  logic             lat_id;
  logic [1:0]       lat_sel;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;

  logic [WIDTH-1:0] c_result;
  logic             c_cout, c_gt, c_eq, c_lt;

`ifdef ALU_SCHED_RR_EN
  logic last;

  // Remember the last winner so a tie goes to the other side
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last <= 1'b1;
    else if (grant) last <= pick1;
  end

  assign pick1 = req1_valid & (~req0_valid | ~last);
`else
  assign pick1 = req1_valid & ~req0_valid;
`endif

  assign grant = (state == IDLE) & ~reset
               & (req0_valid | req1_valid);
  assign req0_ready = grant & ~pick1;
  assign req1_ready = grant & pick1;

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant) state_nx = EXEC;
      EXEC: state_nx = HOLD;
      HOLD: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the granted operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_id  <= 1'b0;
      lat_sel <= 2'b00;
      lat_a   <= '0;
      lat_b   <= '0;
    end else if (grant) begin
      lat_id  <= pick1;
      lat_sel <= pick1 ? req1_sel : req0_sel;
      lat_a   <= pick1 ? req1_a : req0_a;
      lat_b   <= pick1 ? req1_b : req0_b;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (lat_a),
    .b      (lat_b),
    .sel    (lat_sel),
    .result (c_result),
    .cout   (c_cout),
    .gt     (c_gt),
    .eq     (c_eq),
    .lt     (c_lt)
  );

  // Register result fields at the end of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_id     <= 1'b0;
      out_result <= '0;
      out_cout   <= 1'b0;
      out_gt     <= 1'b0;
      out_eq     <= 1'b0;
      out_lt     <= 1'b0;
    end else if (state == EXEC) begin
      out_id     <= lat_id;
      out_result <= c_result;
      out_cout   <= c_cout;
      out_gt     <= c_gt;
      out_eq     <= c_eq;
      out_lt     <= c_lt;
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_sel, req1_sel;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       out_valid, out_ready, out_id;
  logic [7:0] out_result;
  logic       out_cout, out_gt, out_eq, out_lt, busy;

  int tests = 0;
  int fails = 0;

`ifdef ALU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_scheduler #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_gt     (out_gt),
    .out_eq     (out_eq),
    .out_lt     (out_lt),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag,
                           input logic [7:0] r,
                           input logic c, g, e, l);
    chk({tag, " result"}, {24'd0, out_result}, {24'd0, r});
    chk({tag, " cout"}, {31'd0, out_cout}, {31'd0, c});
    chk({tag, " gt"}, {31'd0, out_gt}, {31'd0, g});
    chk({tag, " eq"}, {31'd0, out_eq}, {31'd0, e});
    chk({tag, " lt"}, {31'd0, out_lt}, {31'd0, l});
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_sel = 2'b00;
    req0_a = 8'hF0; req0_b = 8'h20;
    req1_valid = 1'b0; req1_sel = 2'b00;
    req1_a = 8'h00; req1_b = 8'h00;

    // Reset state with a request already waiting
    @(negedge clk);
    chk("rst out_valid", {31'd0, out_valid}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst req0_ready", {31'd0, req0_ready}, 0);
    chk("rst result", {24'd0, out_result}, 0);
    reset = 1'b0;

    // Req0 add F0+20, accepted in T
    #1;
    chk("add grant0", {31'd0, req0_ready}, 1);
    chk("add grant1", {31'd0, req1_ready}, 0);
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 8'h00;
    chk("add T+1 busy", {31'd0, busy}, 1);
    chk("add T+1 valid", {31'd0, out_valid}, 0);
    chk("add T+1 ready", {31'd0, req0_ready}, 0);
    @(negedge clk);
    chk("add T+2 valid", {31'd0, out_valid}, 1);
    chk("add id", {31'd0, out_id}, 0);
    chk_flags("add", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("add done valid", {31'd0, out_valid}, 0);
    chk("add done busy", {31'd0, busy}, 0);

    // Req1 sub 05-07
    req1_valid = 1'b1; req1_sel = 2'b01;
    req1_a = 8'h05; req1_b = 8'h07;
    #1;
    chk("sub grant1", {31'd0, req1_ready}, 1);
    chk("sub grant0", {31'd0, req0_ready}, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("sub valid", {31'd0, out_valid}, 1);
    chk("sub id", {31'd0, out_id}, 1);
    chk_flags("sub", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Req1 compare 33 vs 33
    req1_valid = 1'b1; req1_sel = 2'b11;
    req1_a = 8'h33; req1_b = 8'h33;
    #1;
    chk("cmp grant1", {31'd0, req1_ready}, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("cmp valid", {31'd0, out_valid}, 1);
    chk_flags("cmpeq", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);

    // Four back-to-back ties with the consumer always ready
    req0_valid = 1'b1; req0_sel = 2'b00;
    req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_sel = 2'b00;
    req1_a = 8'h10; req1_b = 8'h20;
    for (int i = 0; i < 4; i++) begin
      logic eid;
      eid = RR ? logic'(i % 2) : 1'b0;
      #1;
      chk("tie ready0", {31'd0, req0_ready}, {31'd0, ~eid});
      chk("tie ready1", {31'd0, req1_ready}, {31'd0, eid});
      @(negedge clk);
      @(negedge clk);
      chk("tie valid", {31'd0, out_valid}, 1);
      chk("tie id", {31'd0, out_id}, {31'd0, eid});
      chk("tie result", {24'd0, out_result},
          eid ? 32'h30 : 32'h03);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    // Backpressure on AND CC&0F with both requesters pending
    req0_valid = 1'b1; req0_sel = 2'b10;
    req0_a = 8'hCC; req0_b = 8'h0F;
    req1_valid = 1'b1;
    #1;
    chk("and grant0", {31'd0, req0_ready}, 1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", {31'd0, out_valid}, 1);
      chk_flags("bp", 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp ready0", {31'd0, req0_ready}, 0);
      chk("bp ready1", {31'd0, req1_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("post bp ready0", {31'd0, req0_ready}, {31'd0, ~RR});
    chk("post bp ready1", {31'd0, req1_ready}, {31'd0, RR});

    // Reset while in EXEC
    @(negedge clk);
    chk("exec busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("mid rst valid", {31'd0, out_valid}, 0);
    chk("mid rst busy", {31'd0, busy}, 0);
    chk("mid rst result", {24'd0, out_result}, 0);
    chk("mid rst ready0", {31'd0, req0_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst tie ready0", {31'd0, req0_ready}, 1);
    chk("rst tie ready1", {31'd0, req1_ready}, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rst tie valid", {31'd0, out_valid}, 1);
    chk("rst tie id", {31'd0, out_id}, 0);
    chk("rst tie result", {24'd0, out_result}, 32'h0C);
    out_ready = 1'b1;
    @(negedge clk);
    chk("end idle", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
